// File: rtl/serial_alu_if.sv
// Shared ALU types and the request/response handshake bundle for serial_alu.
// Masters drive requests and accept responses; the slave modport is the ALU side.

package serial_alu_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    AluNop,
    AluAdd,
    AluSub,
    AluSlt,
    AluSltu,
    AluXor,
    AluOr,
    AluAnd,
    AluSll,
    AluSrl,
    AluSra
  } alu_fn_t;
endpackage

interface serial_alu_if;
  logic                     req_valid;
  logic                     req_ready;
  serial_alu_pkg::alu_fn_t  req_fn;
  serial_alu_pkg::word_t    req_a;
  serial_alu_pkg::word_t    req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  serial_alu_pkg::word_t    rsp_r;

  modport master (
    output req_valid, req_fn, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_r
  );

  modport slave (
    input  req_valid, req_fn, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_r
  );
endinterface

// File: rtl/serial_alu.sv
// Multi-cycle ALU with valid/ready handshakes; shifts iterate one bit per cycle unless
// SERIAL_ALU_BARREL_SHIFT_EN is defined, in which case every op completes at acceptance.

module serial_alu
  import serial_alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  serial_alu_if.slave  bus
);

`ifdef SERIAL_ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {StIdle, StDone} state_t;
`else
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;
  typedef enum logic [1:0] {ShLeft, ShRight, ShArith} shift_kind_t;
`endif

  state_t state_q, state_d;
  word_t  rsp_q, rsp_d;

  function automatic word_t alu_result(alu_fn_t fn, word_t a, word_t b);
    word_t r;
    case (fn)
      AluAdd:  r = a + b;
      AluSub:  r = a - b;
      AluSlt:  r = {31'b0, ($signed(a) < $signed(b))};
      AluSltu: r = {31'b0, (a < b)};
      AluXor:  r = a ^ b;
      AluOr:   r = a | b;
      AluAnd:  r = a & b;
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
      AluSll:  r = a << b[4:0];
      AluSrl:  r = a >> b[4:0];
      AluSra:  r = word_t'($signed(a) >>> b[4:0]);
`endif
      // Unused encodings (and, in the iterative build, shifts) fall back to NOP.
      default: r = b;
    endcase
    return r;
  endfunction

`ifndef SERIAL_ALU_BARREL_SHIFT_EN
  word_t       acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  shift_kind_t kind_q, kind_d;
  word_t       acc_step;
  logic        req_is_shift;
  shift_kind_t req_kind;

  always_comb begin
    acc_step = acc_q;
    unique case (kind_q)
      ShLeft:  acc_step = {acc_q[30:0], 1'b0};
      ShRight: acc_step = {1'b0, acc_q[31:1]};
      ShArith: acc_step = {acc_q[31], acc_q[31:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    req_is_shift = 1'b1;
    req_kind     = ShLeft;
    case (bus.req_fn)
      AluSll:  req_kind = ShLeft;
      AluSrl:  req_kind = ShRight;
      AluSra:  req_kind = ShArith;
      default: req_is_shift = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
`ifndef SERIAL_ALU_BARREL_SHIFT_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    kind_d  = kind_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StDone;
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
          rsp_d   = alu_result(bus.req_fn, bus.req_a, bus.req_b);
`else
          if (!req_is_shift) begin
            rsp_d = alu_result(bus.req_fn, bus.req_a, bus.req_b);
          end else if (bus.req_b[4:0] == 5'd0) begin
            rsp_d = bus.req_a;
          end else begin
            acc_d   = bus.req_a;
            cnt_d   = bus.req_b[4:0];
            kind_d  = req_kind;
            state_d = StShift;
          end
`endif
        end
      end
`ifndef SERIAL_ALU_BARREL_SHIFT_EN
      StShift: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 5'd1;
        // Last step: publish the shifted value on the same edge the counter hits zero.
        if (cnt_q == 5'd1) begin
          rsp_d   = acc_step;
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

`ifndef SERIAL_ALU_BARREL_SHIFT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kind_q <= ShLeft;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end
`endif

  // Handshake outputs come straight from registered state.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_r     = rsp_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed + random bench for serial_alu: scoreboard queue of expected results, latency
// checks, backpressure and asynchronous reset during a shift.

module tb_serial_alu;
  import serial_alu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  word_t exp_q[$];

  serial_alu_if bus ();

  serial_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic word_t model(input alu_fn_t fn, input word_t a, input word_t b);
    case (fn)
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      AluSltu: return (a < b) ? 32'd1 : 32'd0;
      AluXor:  return a ^ b;
      AluOr:   return a | b;
      AluAnd:  return a & b;
      AluSll:  return a << b[4:0];
      AluSrl:  return a >> b[4:0];
      AluSra:  return word_t'($signed(a) >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  function automatic int exp_lat(input alu_fn_t fn, input word_t b);
`ifdef SERIAL_ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((fn == AluSll || fn == AluSrl || fn == AluSra) && b[4:0] != 5'd0)
      return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // One full transaction with rsp_ready held high; checks latency, result, return to idle.
  task automatic run_op(input string tag, input alu_fn_t fn, input word_t a, input word_t b,
                        input word_t exp_r);
    int edges;
    word_t got;
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_fn    = fn;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = 1'b1;
    exp_q.push_back(exp_r);
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; they must not matter.
    bus.req_valid = 1'b0;
    bus.req_fn    = AluAdd;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    edges = 1;
    while (!bus.rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'(exp_lat(fn, b)));
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    got = bus.rsp_r;
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      check({tag, "_rsp_r"}, got, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    alu_fn_t fn;
    word_t   a;
    word_t   b;

    bus.req_valid = 1'b0;
    bus.req_fn    = AluNop;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    #2;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_r", bus.rsp_r, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("add", AluAdd, 32'd10, 32'd20, 32'd30);
    run_op("sub", AluSub, 32'd10, 32'd20, 32'hFFFF_FFF6);
    run_op("slt_neg_a", AluSlt, -32'sd10, 32'd20, 32'd1);
    run_op("sltu_neg_a", AluSltu, -32'sd10, 32'd20, 32'd0);
    run_op("slt_neg_b", AluSlt, 32'd10, -32'sd20, 32'd0);
    run_op("sltu_neg_b", AluSltu, 32'd10, -32'sd20, 32'd1);
    run_op("sra12", AluSra, 32'hF000_5432, 32'd12, 32'hFFFF_0005);
    run_op("srl12", AluSrl, 32'hF000_5432, 32'd12, 32'h000F_0005);
    run_op("sll12", AluSll, 32'h0001_2345, 32'd12, 32'h1234_5000);
    run_op("sll0", AluSll, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
    run_op("sll31", AluSll, 32'd1, 32'd31, 32'h8000_0000);
    run_op("or", AluOr, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    run_op("and", AluAnd, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    run_op("unknown_fn", alu_fn_t'(4'd14), 32'd1, 32'd7, 32'd7);

    // Backpressure: response held for five cycles, stray request ignored.
    @(negedge clk);
    check("bp_req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_fn    = AluXor;
    bus.req_a     = 32'b0011;
    bus.req_b     = 32'b0101;
    bus.rsp_ready = 1'b0;
    exp_q.push_back(32'b0110);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_r_stable", bus.rsp_r, exp_q[0]);
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_fn    = AluAdd;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd200;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check("bp_rsp_r", bus.rsp_r, exp_q.pop_front());
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_phantom", 32'(bus.rsp_valid), 32'd0);

    // Reset asserted in the middle of a 20-step shift.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_fn    = AluSll;
    bus.req_a     = 32'h0001_2345;
    bus.req_b     = 32'd20;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
`ifndef SERIAL_ALU_BARREL_SHIFT_EN
    check("rst_mid_busy", 32'(bus.req_ready), 32'd0);
`endif
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_async_ready", 32'(bus.req_ready), 32'd1);
    check("rst_async_rsp_r", bus.rsp_r, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("nop_after_rst", AluNop, 32'd10, 32'd20, 32'd20);

    // Random ops against the reference model, including unused encodings.
    for (int i = 0; i < 16; i++) begin
      fn = alu_fn_t'(4'($urandom_range(0, 12)));
      a  = $urandom;
      b  = $urandom;
      run_op("rand", fn, a, b, model(fn, a, b));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
